// File: rtl/mtr_cmd_shaper.sv
// rtl/mtr_cmd_shaper.sv - saturating, slew-limited motor command shaper with watchdog ramp-down
//
// Purpose: clamps the raw signed left/right commands to +/-SAT, limits each
// output update to SLEW, gates everything on rider power-up and ramps both
// outputs to zero (one step every STOP_DIV cycles) when power drops or the
// controller stops sending samples for WD_CYC cycles.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   vld      in   one-cycle strobe qualifying lft_cmd/rht_cmd
//   lft_cmd  in   [15:0] signed raw left command
//   rht_cmd  in   [15:0] signed raw right command
//   pwr_up   in   rider present, motors enabled (level)
//   lft_out  out  [15:0] signed shaped left output (registered)
//   rht_out  out  [15:0] signed shaped right output (registered)
//   out_vld  out  one-cycle pulse when new output values first appear
//   sat      out  last accepted sample was clamped on either side
//   stale    out  watchdog tripped; sticky until the next entry to RUN

module mtr_cmd_shaper #(
    parameter logic [15:0] SAT      = 16'h3FFF,
    parameter logic [15:0] SLEW     = 16'h0200,
    parameter int unsigned STOP_DIV = 1024,
    parameter int unsigned WD_CYC   = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic signed [15:0] lft_cmd,
    input  logic signed [15:0] rht_cmd,
    input  logic               pwr_up,
    output logic signed [15:0] lft_out,
    output logic signed [15:0] rht_out,
    output logic               out_vld,
    output logic               sat,
    output logic               stale
);

    localparam int unsigned DIV_W = (STOP_DIV > 1) ? $clog2(STOP_DIV) : 1;

    localparam logic signed [15:0] SAT_S    = SAT;
    localparam logic signed [15:0] NSAT_S   = -SAT_S;
    localparam logic signed [15:0] SLEW_S   = SLEW;
    localparam logic signed [16:0] SLEW_X   = {1'b0, SLEW};
    localparam logic signed [16:0] NSLEW_X  = -SLEW_X;
    localparam logic [23:0]        WD_LAST  = 24'(WD_CYC - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(STOP_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic signed [15:0] lft_q, lft_d;
    logic signed [15:0] rht_q, rht_d;
    logic               out_vld_q, out_vld_d;
    logic               sat_q, sat_d;
    logic               stale_q, stale_d;
    logic [23:0]        wd_q, wd_d;
    logic [DIV_W-1:0]   div_q, div_d;

    logic signed [15:0] lft_tgt, rht_tgt;
    logic               lft_clamped, rht_clamped;

    function automatic logic signed [15:0] clamp(input logic signed [15:0] cmd);
        if (cmd > SAT_S) begin
            clamp = SAT_S;
        end else if (cmd < NSAT_S) begin
            clamp = NSAT_S;
        end else begin
            clamp = cmd;
        end
    endfunction

    // The difference is formed in 17 bits so a full-scale swing cannot wrap.
    // Because cur and tgt both sit inside +/-SAT, the +/-SLEW moves only
    // happen when the target is further away, so they cannot overflow.
    function automatic logic signed [15:0] slew_step(input logic signed [15:0] tgt,
                                                     input logic signed [15:0] cur);
        logic signed [16:0] d;
        d = {tgt[15], tgt} - {cur[15], cur};
        if (d > SLEW_X) begin
            slew_step = cur + SLEW_S;
        end else if (d < NSLEW_X) begin
            slew_step = cur - SLEW_S;
        end else begin
            slew_step = tgt;
        end
    endfunction

    always_comb begin
        lft_tgt     = clamp(lft_cmd);
        rht_tgt     = clamp(rht_cmd);
        lft_clamped = (lft_tgt != lft_cmd);
        rht_clamped = (rht_tgt != rht_cmd);
    end

    always_comb begin
        state_d   = state_q;
        lft_d     = lft_q;
        rht_d     = rht_q;
        out_vld_d = 1'b0;
        sat_d     = sat_q;
        stale_d   = stale_q;
        wd_d      = wd_q;
        div_d     = div_q;

        case (state_q)
            ST_IDLE: begin
                lft_d = '0;
                rht_d = '0;
                wd_d  = '0;
                div_d = '0;
                if (pwr_up) begin
                    state_d = ST_RUN;
                    stale_d = 1'b0;
                end
            end

            ST_RUN: begin
                div_d = '0;
                // A power drop discards any sample arriving in the same cycle.
                if (!pwr_up) begin
                    state_d = ST_STOP;
                end else if (vld) begin
                    lft_d     = slew_step(lft_tgt, lft_q);
                    rht_d     = slew_step(rht_tgt, rht_q);
                    sat_d     = lft_clamped | rht_clamped;
                    out_vld_d = 1'b1;
                    wd_d      = '0;
                end else if (wd_q == WD_LAST) begin
                    stale_d = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    wd_d = wd_q + 24'd1;
                end
            end

            ST_STOP: begin
                if ((lft_q == '0) && (rht_q == '0)) begin
                    state_d = ST_IDLE;
                end else if (div_q == DIV_LAST) begin
                    lft_d     = slew_step('0, lft_q);
                    rht_d     = slew_step('0, rht_q);
                    out_vld_d = 1'b1;
                    div_d     = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lft_q     <= '0;
            rht_q     <= '0;
            out_vld_q <= 1'b0;
            sat_q     <= 1'b0;
            stale_q   <= 1'b0;
            wd_q      <= '0;
            div_q     <= '0;
        end else begin
            state_q   <= state_d;
            lft_q     <= lft_d;
            rht_q     <= rht_d;
            out_vld_q <= out_vld_d;
            sat_q     <= sat_d;
            stale_q   <= stale_d;
            wd_q      <= wd_d;
            div_q     <= div_d;
        end
    end

    assign lft_out = lft_q;
    assign rht_out = rht_q;
    assign out_vld = out_vld_q;
    assign sat     = sat_q;
    assign stale   = stale_q;

endmodule

// File: tb/tb_mtr_cmd_shaper.sv
// tb/tb_mtr_cmd_shaper.sv - scoreboard bench for mtr_cmd_shaper against an integer reference model

module tb_mtr_cmd_shaper;

    localparam logic [15:0] P_SAT      = 16'h1000;
    localparam logic [15:0] P_SLEW     = 16'h0100;
    localparam int          P_STOP_DIV = 4;
    localparam int          P_WD_CYC   = 16;

    localparam int SAT_I  = 4096;
    localparam int SLEW_I = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic [15:0] lft_cmd = '0;
    logic [15:0] rht_cmd = '0;
    logic        pwr_up = 1'b0;
    logic [15:0] lft_out, rht_out;
    logic        out_vld, sat, stale;

    mtr_cmd_shaper #(
        .SAT      (P_SAT),
        .SLEW     (P_SLEW),
        .STOP_DIV (P_STOP_DIV),
        .WD_CYC   (P_WD_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld     (vld),
        .lft_cmd (lft_cmd),
        .rht_cmd (rht_cmd),
        .pwr_up  (pwr_up),
        .lft_out (lft_out),
        .rht_out (rht_out),
        .out_vld (out_vld),
        .sat     (sat),
        .stale   (stale)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        s;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: motors on/off/ramping, outputs as plain integers.
    bit m_on;        // rider session active, accepting samples
    bit m_ramping;   // ramping toward zero
    int m_l, m_r;
    bit m_sat, m_stale, m_pulse;
    int m_quiet;     // consecutive strobe-less cycles while on
    int m_age;       // cycles since ramp-down began

    function automatic int clampv(int c);
        if (c > SAT_I) return SAT_I;
        if (c < -SAT_I) return -SAT_I;
        return c;
    endfunction

    function automatic int stepv(int tgt, int cur);
        int d;
        d = tgt - cur;
        if (d > SLEW_I) return cur + SLEW_I;
        if (d < -SLEW_I) return cur - SLEW_I;
        return tgt;
    endfunction

    task automatic model_reset();
        m_on = 0; m_ramping = 0;
        m_l = 0; m_r = 0;
        m_sat = 0; m_stale = 0; m_pulse = 0;
        m_quiet = 0; m_age = 0;
        sb.delete();
    endtask

    task automatic push_exp();
        exp_t e;
        e.l = 16'(m_l);
        e.r = 16'(m_r);
        e.s = m_sat;
        sb.push_back(e);
        m_pulse = 1;
    endtask

    // What one rising edge does, given the inputs sampled on it.
    task automatic model_edge(bit v, logic [15:0] lc, logic [15:0] rc, bit p);
        int tl, tr, cl, cr;
        m_pulse = 0;
        if (m_ramping) begin
            if (m_l == 0 && m_r == 0) begin
                m_ramping = 0;
            end else begin
                m_age++;
                if (m_age % P_STOP_DIV == 0) begin
                    m_l = stepv(0, m_l);
                    m_r = stepv(0, m_r);
                    push_exp();
                end
            end
        end else if (m_on) begin
            if (!p) begin
                m_on = 0; m_ramping = 1; m_age = 0;
            end else if (v) begin
                cl = int'($signed(lc));
                cr = int'($signed(rc));
                tl = clampv(cl);
                tr = clampv(cr);
                m_sat = (tl != cl) || (tr != cr);
                m_l = stepv(tl, m_l);
                m_r = stepv(tr, m_r);
                m_quiet = 0;
                push_exp();
            end else begin
                m_quiet++;
                if (m_quiet == P_WD_CYC) begin
                    m_stale = 1;
                    m_on = 0; m_ramping = 1; m_age = 0;
                end
            end
        end else if (p) begin
            m_on = 1; m_quiet = 0; m_stale = 0;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        chk("out_vld", {31'd0, out_vld}, {31'd0, m_pulse});
        chk("stale", {31'd0, stale}, {31'd0, m_stale});
        chk("sat", {31'd0, sat}, {31'd0, m_sat});
        if (out_vld === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_vld", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("lft_out", {16'd0, lft_out}, {16'd0, e.l});
                chk("rht_out", {16'd0, rht_out}, {16'd0, e.r});
                chk("sat_on_vld", {31'd0, sat}, {31'd0, e.s});
            end
        end else begin
            chk("lft_hold", {16'd0, lft_out}, {16'd0, 16'(m_l)});
            chk("rht_hold", {16'd0, rht_out}, {16'd0, 16'(m_r)});
        end
    end

    task automatic cyc(bit v, logic [15:0] l, logic [15:0] r, bit p);
        vld = v; lft_cmd = l; rht_cmd = r; pwr_up = p;
        @(posedge clk);
        model_edge(v, l, r, p);
        #1;
    endtask

    task automatic reset_cycles(int n);
        rst_n = 1'b0;
        vld = 1'b0;
        model_reset();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        reset_cycles(3);

        // Strobes with power down are ignored.
        repeat (3) cyc(1, 16'h0500, 16'h0000, 0);
        chk("idle_lft", {16'd0, lft_out}, 32'd0);

        // Power up, first small sample passes straight through.
        cyc(0, 16'h0000, 16'h0000, 1);
        cyc(1, 16'h0080, 16'hFFB0, 1);
        cyc(0, 16'h0000, 16'h0000, 1);

        // Saturated back-to-back strobes slew up to the clamp.
        repeat (20) cyc(1, 16'h7000, 16'h8000, 1);
        chk("sat_lft_limit", {16'd0, lft_out}, 32'h0000_1000);
        chk("sat_rht_limit", {16'd0, rht_out}, 32'h0000_F000);

        // Settle at 0250/0000 then drop power with stray strobes.
        repeat (20) cyc(1, 16'h0250, 16'h0000, 1);
        chk("pre_ramp_lft", {16'd0, lft_out}, 32'h0000_0250);
        for (int i = 0; i < 20; i++) cyc(i[0], 16'h0700, 16'h0300, 0);
        chk("ramp_done_lft", {16'd0, lft_out}, 32'd0);

        // Watchdog trip: 16 quiet cycles with power held high.
        cyc(0, 16'h0000, 16'h0000, 1);
        repeat (4) cyc(1, 16'h0300, 16'hFD00, 1);
        repeat (16) cyc(0, 16'h0000, 16'h0000, 1);
        chk("wd_trip_stale", {31'd0, stale}, 32'd1);
        repeat (25) cyc(0, 16'h0000, 16'h0000, 1);
        // Back in RUN: strobe in the 16th quiet cycle prevents a trip.
        cyc(1, 16'h0200, 16'h0000, 1);
        chk("rerun_stale", {31'd0, stale}, 32'd0);
        repeat (15) cyc(0, 16'h0000, 16'h0000, 1);
        cyc(1, 16'h0200, 16'h0000, 1);
        repeat (3) cyc(0, 16'h0000, 16'h0000, 1);
        chk("no_trip_stale", {31'd0, stale}, 32'd0);

        // Randomized traffic including extremes, power toggles and long gaps.
        for (int i = 0; i < 600; i++) begin
            logic [15:0] l, r;
            bit v, p;
            case ($urandom_range(0, 3))
                0: l = 16'h8000;
                1: l = 16'h7FFF;
                default: l = 16'($urandom);
            endcase
            r = ($urandom_range(0, 4) == 0) ? 16'hF000 : 16'($urandom_range(0, 16'h2400) - 16'h1200);
            p = ($urandom_range(0, 59) == 0) ? ~pwr_up : pwr_up;
            if (i % 100 > 80) v = 0;
            else v = ($urandom_range(0, 3) != 0);
            cyc(v, l, r, p);
        end

        // Reset mid-ramp: drive to a stale ramp-down, then reset asynchronously.
        repeat (3) cyc(0, 16'h0000, 16'h0000, 0);
        repeat (20) cyc(0, 16'h0000, 16'h0000, 0);
        cyc(0, 16'h0000, 16'h0000, 1);
        repeat (10) cyc(1, 16'h0A00, 16'hF600, 1);
        repeat (16) cyc(0, 16'h0000, 16'h0000, 1);
        repeat (9) cyc(0, 16'h0000, 16'h0000, 1);
        chk("mid_ramp_stale", {31'd0, stale}, 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_lft", {16'd0, lft_out}, 32'd0);
        chk("async_rst_rht", {16'd0, rht_out}, 32'd0);
        chk("async_rst_stale", {31'd0, stale}, 32'd0);
        chk("async_rst_vld", {31'd0, out_vld}, 32'd0);
        reset_cycles(2);
        // Back in IDLE: strobes without power produce nothing.
        repeat (3) cyc(1, 16'h0400, 16'h0400, 0);
        chk("post_rst_idle", {16'd0, lft_out}, 32'd0);
        repeat (2) cyc(0, 16'h0000, 16'h0000, 0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
